// File: rtl/vga_pkg.sv
// Shared constants for the dual-image VGA scan: the 640x480@60 reference raster,
// the display FSM states and the record carried down the sync/region delay pipeline.
package vga_pkg;

    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHOW
    } scan_state_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_n;
        logic sel_f;
        logic in_img;
    } pipe_t;

    localparam pipe_t PIPE_RESET = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0,
                                     sel_f: 1'b0, in_img: 1'b0};

    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: divides CLK down to a one-cycle pixel enable and runs the horizontal and
// vertical scan counters, deriving raw (undelayed) syncs and the active-region flag.
module vga_timing
    import vga_pkg::*;
#(
    parameter int DIV    = 2,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int CW     = 10
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          pix_ce,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          hsync_raw,
    output logic          vsync_raw,
    output logic          blank_raw
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int DW    = $clog2(DIV);

    logic [DW-1:0] div_cnt;

    assign pix_ce = (div_cnt == DW'(DIV - 1));

    // The divider restarts from zero on reset, so the first pixel tick lands DIV clocks later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt <= '0;
            hcnt    <= '0;
            vcnt    <= '0;
        end else begin
            div_cnt <= pix_ce ? '0 : div_cnt + DW'(1);
            if (pix_ce) begin
                if (hcnt == CW'(H_TOT - 1)) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == CW'(V_TOT - 1)) ? '0 : vcnt + CW'(1);
                end else begin
                    hcnt <= hcnt + CW'(1);
                end
            end
        end
    end

    assign hsync_raw = !in_window(int'(hcnt), H_ACT + H_FP, H_SYNC);
    assign vsync_raw = !in_window(int'(vcnt), V_ACT + V_FP, V_SYNC);
    assign blank_raw = (int'(hcnt) < H_ACT) && (int'(vcnt) < V_ACT);

endmodule

// File: rtl/vga_dual_scan.sv
// vga_dual_scan: shows the noisy (left) and filtered (right) images side by side on a VGA raster.
// Define VGA_BORDER_EN to frame both images with a one-pixel white border while displaying.
module vga_dual_scan
    import vga_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 16,
    parameter int DIV     = 2,
    parameter int H_ACT   = 640,
    parameter int H_FP    = H_SYNC_START - 640,
    parameter int H_SYNC  = H_SYNC_END - H_SYNC_START,
    parameter int H_BP    = H_TOTAL - H_SYNC_END,
    parameter int V_ACT   = 480,
    parameter int V_FP    = V_SYNC_START - 480,
    parameter int V_SYNC  = V_SYNC_END - V_SYNC_START,
    parameter int V_BP    = V_TOTAL - V_SYNC_END,
    parameter int X0_N    = 32,
    parameter int X0_F    = 352,
    parameter int Y0      = 112
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               VGA_EN,
    input  logic [D_WIDTH-1:0] VGA_DATA,
    input  logic [D_WIDTH-1:0] VGA_DATA_N,
    output logic [A_WIDTH-1:0] VGA_ADDR,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               BLANK_N,
    output logic [3:0]         R,
    output logic [3:0]         G,
    output logic [3:0]         B
);

    localparam int HALF  = A_WIDTH / 2;
    localparam int IMG   = 1 << HALF;
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int CW    = $clog2(H_TOT > V_TOT ? H_TOT : V_TOT);

    logic          pix_ce;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          hsync_raw;
    logic          vsync_raw;
    logic          blank_raw;

    vga_timing #(
        .DIV(DIV), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CW(CW)
    ) u_timing (
        .CLK(CLK),
        .RST(RST),
        .pix_ce(pix_ce),
        .hcnt(hcnt),
        .vcnt(vcnt),
        .hsync_raw(hsync_raw),
        .vsync_raw(vsync_raw),
        .blank_raw(blank_raw)
    );

    int                 hpos;
    int                 vpos;
    logic               in_n;
    logic               in_f;
    logic [A_WIDTH-1:0] addr_n;
    logic [A_WIDTH-1:0] addr_f;
    logic               show_px;
    scan_state_t        state;
    pipe_t              pipe_a;
    pipe_t              pipe_b;
    logic [D_WIDTH-1:0] gray;
    logic [3:0]         rgb;

    always_comb begin
        hpos   = int'(hcnt);
        vpos   = int'(vcnt);
        in_n   = in_window(hpos, X0_N, IMG) && in_window(vpos, Y0, IMG);
        in_f   = in_window(hpos, X0_F, IMG) && in_window(vpos, Y0, IMG);
        addr_n = {HALF'(vpos - Y0), HALF'(hpos - X0_N)};
        addr_f = {HALF'(vpos - Y0), HALF'(hpos - X0_F)};
    end

`ifdef VGA_BORDER_EN
    logic border;
    logic border_a;
    logic border_b;

    always_comb begin
        border = !(in_n || in_f) && in_window(vpos, Y0 - 1, IMG + 2) &&
                 (in_window(hpos, X0_N - 1, IMG + 2) || in_window(hpos, X0_F - 1, IMG + 2));
    end
`endif

    // Dropping VGA_EN blanks the very next pixel even if the FSM has not yet left SHOW.
    assign show_px = (state == SHOW) && VGA_EN;

    // Address issue, data capture and colour form a three-tick pipeline; the sync record rides
    // along from the address stage so that HSYNC/VSYNC/BLANK_N leave aligned with the colour.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            VGA_ADDR <= '0;
            pipe_a   <= PIPE_RESET;
            pipe_b   <= PIPE_RESET;
            gray     <= '0;
            rgb      <= '0;
            HSYNC    <= 1'b1;
            VSYNC    <= 1'b1;
            BLANK_N  <= 1'b0;
`ifdef VGA_BORDER_EN
            border_a <= 1'b0;
            border_b <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:    if (VGA_EN) state <= ARMED;
                ARMED:   if (!VGA_EN) state <= IDLE;
                         else if (pix_ce && hcnt == '0 && vcnt == '0) state <= SHOW;
                SHOW:    if (!VGA_EN) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (pix_ce) begin
                if (in_n) begin
                    VGA_ADDR <= addr_n;
                end else if (in_f) begin
                    VGA_ADDR <= addr_f;
                end
                pipe_a  <= '{hsync: hsync_raw, vsync: vsync_raw, blank_n: blank_raw,
                             sel_f: in_f, in_img: in_n | in_f};
                pipe_b  <= pipe_a;
                gray    <= pipe_a.sel_f ? VGA_DATA : VGA_DATA_N;
                HSYNC   <= pipe_b.hsync;
                VSYNC   <= pipe_b.vsync;
                BLANK_N <= pipe_b.blank_n;
`ifdef VGA_BORDER_EN
                border_a <= border;
                border_b <= border_a;
`endif
                if (show_px && pipe_b.blank_n && pipe_b.in_img) begin
                    rgb <= gray[D_WIDTH-1 -: 4];
`ifdef VGA_BORDER_EN
                end else if (show_px && pipe_b.blank_n && border_b) begin
                    rgb <= 4'hF;
`endif
                end else begin
                    rgb <= '0;
                end
            end
        end
    end

    assign R = rgb;
    assign G = rgb;
    assign B = rgb;

endmodule

// File: tb/tb_vga_dual_scan.sv
// Bench for vga_dual_scan on a shrunken raster (16x16 images): random image contents and random
// enable/reset timing, checked against a screen-position model of what each pixel should show.
`timescale 1ns/1ps
module tb_vga_dual_scan;

    localparam int D_WIDTH = 8;
    localparam int A_WIDTH = 8;
    localparam int DIV     = 2;
    localparam int H_ACT   = 48;
    localparam int H_FP    = 4;
    localparam int H_SYNC  = 6;
    localparam int H_BP    = 4;
    localparam int V_ACT   = 24;
    localparam int V_FP    = 2;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 3;
    localparam int X0_N    = 4;
    localparam int X0_F    = 26;
    localparam int Y0      = 4;
    localparam int IMG     = 1 << (A_WIDTH / 2);
    localparam int H_TOT   = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT   = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOT * V_TOT;
`ifdef VGA_BORDER_EN
    localparam bit BORDER  = 1'b1;
`else
    localparam bit BORDER  = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               VGA_EN = 1'b0;
    logic [D_WIDTH-1:0] VGA_DATA = '0;
    logic [D_WIDTH-1:0] VGA_DATA_N = '0;
    logic [A_WIDTH-1:0] VGA_ADDR;
    logic               HSYNC;
    logic               VSYNC;
    logic               BLANK_N;
    logic [3:0]         R;
    logic [3:0]         G;
    logic [3:0]         B;

    vga_dual_scan #(
        .D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .DIV(DIV),
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .X0_N(X0_N), .X0_F(X0_F), .Y0(Y0)
    ) dut (
        .CLK(CLK), .RST(RST), .VGA_EN(VGA_EN),
        .VGA_DATA(VGA_DATA), .VGA_DATA_N(VGA_DATA_N), .VGA_ADDR(VGA_ADDR),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .BLANK_N(BLANK_N), .R(R), .G(G), .B(B)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       hs;
        bit       vs;
        bit       bl;
        bit       img;
        bit       border;
        bit [3:0] gray;
    } expect_t;

    logic [D_WIDTH-1:0] lut_n [IMG*IMG];
    logic [D_WIDTH-1:0] lut_f [IMG*IMG];
    logic [A_WIDTH-1:0] prev_addr = '0;
    int                 total = 0;
    int                 bad = 0;
    int                 clk_count = 0;
    int                 bh;
    int                 bv;
    bit                 live;
    int                 model_addr;
    expect_t            hist[$];
    bit                 prev_hs;
    bit                 prev_vs;
    int                 hs_fall;
    int                 vs_fall;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h (x=%0d y=%0d t=%0t)", tag, obs, want, bh, bv, $time);
        end
    endtask

    // Upstream controller: filtered pixel follows the address after one clock, noisy after two.
    task automatic clockCycle();
        @(posedge CLK);
        #1;
        clk_count++;
        VGA_DATA   = lut_f[VGA_ADDR];
        VGA_DATA_N = lut_n[prev_addr];
        prev_addr  = VGA_ADDR;
    endtask

    function automatic expect_t posExpect(input int x, input int y);
        expect_t e;
        bit      on_n;
        bit      on_f;
        int      a;
        on_n     = x >= X0_N && x < X0_N + IMG && y >= Y0 && y < Y0 + IMG;
        on_f     = x >= X0_F && x < X0_F + IMG && y >= Y0 && y < Y0 + IMG;
        e.hs     = !(x >= H_ACT + H_FP && x < H_ACT + H_FP + H_SYNC);
        e.vs     = !(y >= V_ACT + V_FP && y < V_ACT + V_FP + V_SYNC);
        e.bl     = x < H_ACT && y < V_ACT;
        e.img    = on_n || on_f;
        a        = (y - Y0) * IMG + (on_n ? x - X0_N : x - X0_F);
        e.gray   = on_n ? lut_n[a][7:4] : (on_f ? lut_f[a][7:4] : 4'h0);
        e.border = !e.img && y >= Y0 - 1 && y <= Y0 + IMG &&
                   ((x >= X0_N - 1 && x <= X0_N + IMG) || (x >= X0_F - 1 && x <= X0_F + IMG));
        return e;
    endfunction

    function automatic int ticksTo(input int x, input int y);
        int d;
        d = (y * H_TOT + x) - (bv * H_TOT + bh);
        if (d <= 0) d += FRAME;
        return d;
    endfunction

    task automatic modelReset();
        expect_t r;
        r = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, img: 1'b0, border: 1'b0, gray: 4'h0};
        bh = 0;
        bv = 0;
        live = 1'b0;
        model_addr = 0;
        hist = {};
        hist.push_back(r);
        hist.push_back(r);
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        hs_fall = -1;
        vs_fall = -1;
    endtask

    // One pixel tick: the window just ended belonged to (bh,bv); outputs now show the pixel
    // from two windows earlier.
    task automatic stepTick();
        expect_t e;
        expect_t o;
        bit      live_before;
        bit      show;
        int      want_rgb;
        repeat (DIV) clockCycle();
        live_before = live;
        e = posExpect(bh, bv);
        hist.push_back(e);
        if (e.img) model_addr = (bv - Y0) * IMG + ((bh >= X0_F) ? bh - X0_F : bh - X0_N);
        if (!VGA_EN) live = 1'b0;
        else if (bh == 0 && bv == 0) live = 1'b1;
        bh++;
        if (bh == H_TOT) begin
            bh = 0;
            bv = (bv == V_TOT - 1) ? 0 : bv + 1;
        end
        o = hist.pop_front();
        show = live_before && VGA_EN;
        want_rgb = (show && o.bl && o.img) ? int'(o.gray) :
                   ((show && o.bl && o.border && BORDER) ? 15 : 0);
        checkOutput("hsync", HSYNC, o.hs);
        checkOutput("vsync", VSYNC, o.vs);
        checkOutput("blank_n", BLANK_N, o.bl);
        checkOutput("red", R, want_rgb);
        checkOutput("green", G, want_rgb);
        checkOutput("blue", B, want_rgb);
        checkOutput("addr", VGA_ADDR, model_addr);
        if (prev_hs && !HSYNC) begin
            if (hs_fall >= 0) checkOutput("hsync_period", clk_count - hs_fall, H_TOT * DIV);
            hs_fall = clk_count;
        end
        if (!prev_hs && HSYNC && hs_fall >= 0) checkOutput("hsync_low", clk_count - hs_fall, H_SYNC * DIV);
        if (prev_vs && !VSYNC) begin
            if (vs_fall >= 0) checkOutput("vsync_period", clk_count - vs_fall, FRAME * DIV);
            vs_fall = clk_count;
        end
        if (!prev_vs && VSYNC && vs_fall >= 0)
            checkOutput("vsync_low", clk_count - vs_fall, V_SYNC * H_TOT * DIV);
        prev_hs = HSYNC;
        prev_vs = VSYNC;
    endtask

    task automatic applyStimulus(input bit en, input int ticks);
        VGA_EN = en;
        repeat (ticks) stepTick();
    endtask

    task automatic resetPulse();
        RST = 1'b1;
        clockCycle();
        checkOutput("rst_hcnt", 32'(dut.u_timing.hcnt), 0);
        checkOutput("rst_vcnt", 32'(dut.u_timing.vcnt), 0);
        checkOutput("rst_hsync", HSYNC, 1);
        checkOutput("rst_vsync", VSYNC, 1);
        checkOutput("rst_blank_n", BLANK_N, 0);
        checkOutput("rst_rgb", R, 0);
        checkOutput("rst_addr", VGA_ADDR, 0);
        RST = 1'b0;
        modelReset();
    endtask

    initial begin
        for (int i = 0; i < IMG * IMG; i++) begin
            lut_n[i] = D_WIDTH'($urandom_range(0, 255));
            lut_f[i] = D_WIDTH'($urandom_range(0, 255));
        end
        RST = 1'b1;
        repeat (2) clockCycle();
        resetPulse();

        applyStimulus(1'b0, 2 * FRAME + 10);
        $display("[TB] enable raised mid-frame");
        applyStimulus(1'b0, ticksTo(0, $urandom_range(5, 25)));
        applyStimulus(1'b1, ticksTo(0, 0) + FRAME);
        $display("[TB] enable dropped inside the image rows");
        applyStimulus(1'b1, ticksTo($urandom_range(0, H_TOT - 1), $urandom_range(Y0 + 1, Y0 + IMG - 2)));
        applyStimulus(1'b0, $urandom_range(FRAME / 4, FRAME / 2));
        applyStimulus(1'b1, ticksTo(0, 0) + $urandom_range(FRAME / 2, FRAME));
        $display("[TB] reset pulse mid-line");
        applyStimulus(1'b1, ticksTo(30, $urandom_range(Y0, Y0 + IMG - 1)));
        resetPulse();
        applyStimulus(1'b1, ticksTo(0, 0) + FRAME);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(50, FRAME / 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
